// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache with a two-state miss FSM.
module icache #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        inv,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             state_q;
    logic [NSETS-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q [NSETS];
    logic [31:0]        data_q [NSETS];
    logic [31:0]        maddr_q, maddr_d, hit_cnt_q, miss_cnt_q;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx, fidx;
    logic               hit, miss;

    assign tag     = imemaddr[31:IDX_W+2];
    assign idx     = imemaddr[IDX_W+1:2];
    assign fidx    = maddr_q[IDX_W+1:2];
    assign maddr_d = imemaddr & 32'hFFFF_FFFC;

    // inv suppresses both outcomes so an invalidate cycle never counts
    assign hit  = state_q == IDLE && imemREN && !inv && valid_q[idx] && tag_q[idx] == tag;
    assign miss = state_q == IDLE && imemREN && !inv && !hit;

    assign ihit     = hit;
    assign imemload = hit ? data_q[idx] : 32'd0;
    assign iREN     = state_q == FETCH;
    assign iaddr    = iREN ? maddr_q : 32'd0;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            maddr_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (inv)
                valid_q <= '0;
            if (hit)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss) begin
                maddr_q    <= maddr_d;
                miss_cnt_q <= miss_cnt_q + 32'd1;
                state_q    <= FETCH;
            end
            // a fill coinciding with inv writes the frame but leaves it invalid
            if (state_q == FETCH && !iwait) begin
                data_q[fidx]  <= iload;
                tag_q[fidx]   <= maddr_q[31:IDX_W+2];
                valid_q[fidx] <= !inv;
                state_q       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed per-cycle vectors; expectations are queued and checked by a separate monitor.
module tb_icache;
    logic        CLK = 0, RST = 1, imemREN = 0, iwait = 1, inv = 0;
    logic [31:0] imemaddr = 0, iload = 0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr, hit_cnt, miss_cnt;

    typedef struct {
        int          cyc;
        logic        h;
        logic [31:0] ld;
        logic        r;
        logic [31:0] a;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, passed = 0, ncyc = 0;

    icache #(.NSETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .inv(inv),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input int c, input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL cycle %0d %s: got %h want %h", c, nm, got, want);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.cyc, "ihit", {31'd0, ihit}, {31'd0, e.h});
                chk(e.cyc, "imemload", imemload, e.ld);
                chk(e.cyc, "iREN", {31'd0, iREN}, {31'd0, e.r});
                chk(e.cyc, "iaddr", iaddr, e.a);
                chk(e.cyc, "hit_cnt", hit_cnt, e.hc);
                chk(e.cyc, "miss_cnt", miss_cnt, e.mc);
            end
        end
    end

    task automatic step(input logic rst, input logic ren, input logic [31:0] a, input logic iv,
                        input logic w, input logic [31:0] ld,
                        input logic eh, input logic [31:0] el, input logic er, input logic [31:0] ea,
                        input int hc, input int mc);
        exp_t e;
        RST = rst; imemREN = ren; imemaddr = a; inv = iv; iwait = w; iload = ld;
        e.cyc = ncyc; e.h = eh; e.ld = el; e.r = er; e.a = ea; e.hc = hc; e.mc = mc;
        exp_q.push_back(e);
        ncyc++;
        @(posedge CLK);
        #1;
    endtask

    initial begin : stim
        @(posedge CLK);
        #1;
        //   rst ren addr         inv w  iload          hit load          iREN iaddr        hc  mc
        step(1, 0, 32'h0,       0, 1, 32'h0,        0, 32'h0,        0, 32'h0,       0,  0);
        // cold fetch 0x40 with three wait cycles
        step(0, 1, 32'h40,      0, 1, 32'h0,        0, 32'h0,        0, 32'h0,       0,  0);
        step(0, 1, 32'h40,      0, 1, 32'h0,        0, 32'h0,        1, 32'h40,      0,  1);
        step(0, 1, 32'h40,      0, 1, 32'h0,        0, 32'h0,        1, 32'h40,      0,  1);
        step(0, 1, 32'h40,      0, 1, 32'h0,        0, 32'h0,        1, 32'h40,      0,  1);
        step(0, 1, 32'h40,      0, 0, 32'h2002_0005, 0, 32'h0,       1, 32'h40,      0,  1);
        step(0, 1, 32'h40,      0, 1, 32'h0,        1, 32'h2002_0005, 0, 32'h0,      0,  1);
        step(0, 0, 32'h40,      0, 1, 32'h0,        0, 32'h0,        0, 32'h0,       1,  1);
        step(0, 1, 32'h43,      0, 1, 32'h0,        1, 32'h2002_0005, 0, 32'h0,      1,  1);
        step(0, 0, 32'h43,      0, 1, 32'h0,        0, 32'h0,        0, 32'h0,       2,  1);
        // conflict eviction on idx 0
        step(0, 1, 32'h0,       0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       2,  1);
        step(0, 1, 32'h0,       0, 0, 32'hAAAA_0000, 0, 32'h0,       1, 32'h0,       2,  2);
        step(0, 1, 32'h0,       0, 0, 32'h0,        1, 32'hAAAA_0000, 0, 32'h0,      2,  2);
        step(0, 1, 32'h40,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       3,  2);
        step(0, 1, 32'h40,      0, 0, 32'hBBBB_0040, 0, 32'h0,       1, 32'h40,      3,  3);
        step(0, 1, 32'h40,      0, 0, 32'h0,        1, 32'hBBBB_0040, 0, 32'h0,      3,  3);
        step(0, 1, 32'h0,       0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       4,  3);
        step(0, 1, 32'h0,       0, 0, 32'hAAAA_0000, 0, 32'h0,       1, 32'h0,       4,  4);
        step(0, 1, 32'h0,       0, 0, 32'h0,        1, 32'hAAAA_0000, 0, 32'h0,      4,  4);
        // redirect to 0x204 while 0x100 is outstanding
        step(0, 1, 32'h100,     0, 1, 32'h0,        0, 32'h0,        0, 32'h0,       5,  4);
        step(0, 1, 32'h204,     0, 1, 32'h0,        0, 32'h0,        1, 32'h100,     5,  5);
        step(0, 1, 32'h204,     0, 0, 32'h1111_0100, 0, 32'h0,       1, 32'h100,     5,  5);
        step(0, 1, 32'h204,     0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       5,  5);
        step(0, 1, 32'h204,     0, 0, 32'h2222_0204, 0, 32'h0,       1, 32'h204,     5,  6);
        step(0, 1, 32'h100,     0, 0, 32'h0,        1, 32'h1111_0100, 0, 32'h0,      5,  6);
        step(0, 1, 32'h204,     0, 0, 32'h0,        1, 32'h2222_0204, 0, 32'h0,      6,  6);
        // invalidate in IDLE, then in a fill cycle
        step(0, 1, 32'h10,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       7,  6);
        step(0, 1, 32'h10,      0, 0, 32'h3333_0010, 0, 32'h0,       1, 32'h10,      7,  7);
        step(0, 1, 32'h10,      0, 0, 32'h0,        1, 32'h3333_0010, 0, 32'h0,      7,  7);
        step(0, 1, 32'h10,      1, 0, 32'h0,        0, 32'h0,        0, 32'h0,       8,  7);
        step(0, 1, 32'h10,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       8,  7);
        step(0, 1, 32'h10,      1, 0, 32'h4444_0010, 0, 32'h0,       1, 32'h10,      8,  8);
        step(0, 1, 32'h10,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       8,  8);
        step(0, 1, 32'h10,      0, 0, 32'h5555_0010, 0, 32'h0,       1, 32'h10,      8,  9);
        step(0, 1, 32'h10,      0, 0, 32'h0,        1, 32'h5555_0010, 0, 32'h0,      8,  9);
        step(0, 1, 32'h204,     0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       9,  9);
        step(0, 1, 32'h204,     0, 0, 32'h6666_0204, 0, 32'h0,       1, 32'h204,     9, 10);
        step(0, 1, 32'h204,     0, 0, 32'h0,        1, 32'h6666_0204, 0, 32'h0,      9, 10);
        // reset mid-miss, late iwait/iload ignored
        step(0, 1, 32'h80,      0, 1, 32'h0,        0, 32'h0,        0, 32'h0,      10, 10);
        step(1, 1, 32'h80,      0, 1, 32'h0,        0, 32'h0,        1, 32'h80,     10, 11);
        step(0, 0, 32'h80,      0, 0, 32'h7777_0080, 0, 32'h0,       0, 32'h0,       0,  0);
        step(0, 1, 32'h80,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       0,  0);
        step(0, 1, 32'h80,      0, 0, 32'h8888_0080, 0, 32'h0,       1, 32'h80,      0,  1);
        step(0, 1, 32'h80,      0, 0, 32'h0,        1, 32'h8888_0080, 0, 32'h0,      0,  1);
        step(0, 1, 32'h10,      0, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1,  1);
        step(0, 1, 32'h10,      0, 0, 32'h9999_0010, 0, 32'h0,       1, 32'h10,      1,  2);
        step(0, 0, 32'h10,      0, 1, 32'h0,        0, 32'h0,        0, 32'h0,       1,  2);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
